// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB plus 2-bit saturating counters.
// Optional global-history (gshare) counter indexing is enabled by defining BP_GSHARE_EN.
module branch_predictor #(
    parameter int IDX_BITS = 6,
    parameter int XLEN     = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] PCF,
    output logic            PredTakenF,
    output logic [XLEN-1:0] PredTargetF,
    input  logic [XLEN-1:0] PCE,
    input  logic [1:0]      BranchOpE,
    input  logic            PCSrcResE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic            PredTakenE,
    input  logic [XLEN-1:0] PredTargetE,
    input  logic            StallE,
    output logic            MispredictE
);
    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = XLEN - IDX_BITS - 2;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    logic                r_valid  [ENTRIES];
    logic [TAG_W-1:0]    r_tag    [ENTRIES];
    logic [XLEN-1:0]     r_target [ENTRIES];
    logic [1:0]          r_cnt    [ENTRIES];

    logic [IDX_BITS-1:0] w_lk_idx;
    logic [IDX_BITS-1:0] w_lk_cidx;
    logic [TAG_W-1:0]    w_lk_tag;
    logic                w_lk_hit;
    logic [IDX_BITS-1:0] w_up_idx;
    logic [IDX_BITS-1:0] w_up_cidx;
    logic [TAG_W-1:0]    w_up_tag;
    logic                w_up_hit;
    logic                w_update;
    logic                w_btb_we;
    logic                w_cnt_we;
    logic [1:0]          w_cnt_next;
    logic                w_unused;

    assign w_lk_idx = PCF[IDX_BITS+1:2];
    assign w_lk_tag = PCF[XLEN-1:IDX_BITS+2];
    assign w_up_idx = PCE[IDX_BITS+1:2];
    assign w_up_tag = PCE[XLEN-1:IDX_BITS+2];
    assign w_update = !StallE && BranchOpE[0];
    assign w_unused = ^{PCF[1:0], PCE[1:0]};

`ifdef BP_GSHARE_EN
    logic [IDX_BITS-1:0] r_ghr;

    assign w_lk_cidx = w_lk_idx ^ r_ghr;
    assign w_up_cidx = w_up_idx ^ r_ghr;

    // Global history shifts in each trained B-type outcome; jumps leave it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ghr <= {IDX_BITS{1'b0}};
        end else if (w_update && BranchOpE == 2'b11) begin
            r_ghr <= {r_ghr[IDX_BITS-2:0], PCSrcResE};
        end
    end
`else
    assign w_lk_cidx = w_lk_idx;
    assign w_up_cidx = w_up_idx;
`endif

    assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

    // Lookup reads registered state only, so a same-cycle update is seen next cycle.
    assign PredTakenF  = w_lk_hit && r_cnt[w_lk_cidx][1];
    assign PredTargetF = w_lk_hit ? r_target[w_lk_idx] : (PCF + XLEN'(3'd4));

    assign MispredictE = BranchOpE[0] &&
                         ((PCSrcResE != PredTakenE) ||
                          (PCSrcResE && (PredTargetE != PCTargetE)));

    // Training decision: which tables to write and the new counter value.
    always_comb begin
        w_btb_we   = 1'b0;
        w_cnt_we   = 1'b0;
        w_cnt_next = r_cnt[w_up_cidx];
        if (w_update) begin
            case (BranchOpE)
                2'b11: begin
                    if (PCSrcResE) begin
                        w_btb_we   = 1'b1;
                        w_cnt_we   = 1'b1;
                        w_cnt_next = w_up_hit ? sat_inc(r_cnt[w_up_cidx]) : CNT_WT;
                    end else if (w_up_hit) begin
                        w_cnt_we   = 1'b1;
                        w_cnt_next = sat_dec(r_cnt[w_up_cidx]);
                    end else begin
                        w_cnt_we   = 1'b0;
                    end
                end
                2'b01: begin
                    w_btb_we   = 1'b1;
                    w_cnt_we   = 1'b1;
                    w_cnt_next = CNT_ST;
                end
                default: begin
                    w_btb_we   = 1'b0;
                    w_cnt_we   = 1'b0;
                end
            endcase
        end else begin
            w_btb_we = 1'b0;
            w_cnt_we = 1'b0;
        end
    end

    // Valid bits and counters; reset wins over any same-cycle training.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_cnt[i]   <= CNT_WNT;
            end
        end else begin
            if (w_btb_we) begin
                r_valid[w_up_idx] <= 1'b1;
            end
            if (w_cnt_we) begin
                r_cnt[w_up_cidx] <= w_cnt_next;
            end
        end
    end

    // Tag and target payload; only meaningful behind a valid bit, so no reset.
    always_ff @(posedge clk) begin
        if (!reset && w_btb_we) begin
            r_tag[w_up_idx]    <= w_up_tag;
            r_target[w_up_idx] <= PCTargetE;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default build, gshare disabled).
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PCF;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    logic [31:0] PCE;
    logic [1:0]  BranchOpE;
    logic        PCSrcResE;
    logic [31:0] PCTargetE;
    logic        PredTakenE;
    logic [31:0] PredTargetE;
    logic        StallE;
    logic        MispredictE;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    branch_predictor #(.IDX_BITS(6), .XLEN(32)) dut (
        .clk(clk), .reset(reset), .PCF(PCF), .PredTakenF(PredTakenF),
        .PredTargetF(PredTargetF), .PCE(PCE), .BranchOpE(BranchOpE),
        .PCSrcResE(PCSrcResE), .PCTargetE(PCTargetE), .PredTakenE(PredTakenE),
        .PredTargetE(PredTargetE), .StallE(StallE), .MispredictE(MispredictE)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        PCE = 32'h0; BranchOpE = 2'b00; PCSrcResE = 1'b0; PCTargetE = 32'h0;
        PredTakenE = 1'b0; PredTargetE = 32'h0; StallE = 1'b0;
    endtask

    task automatic drive_update(input logic [1:0] op, input logic [31:0] pc, input logic taken,
                                input logic [31:0] tgt, input logic ptaken, input logic [31:0] ptgt);
        BranchOpE = op; PCE = pc; PCSrcResE = taken; PCTargetE = tgt;
        PredTakenE = ptaken; PredTargetE = ptgt;
    endtask

    task automatic test_reset();
        logic [31:0] exp_t;
        reset = 1'b1; idle_inputs(); PCF = 32'h100;
        step(); step();
        reset = 1'b0; #4;
        checks++; if (PredTakenF !== 1'b0) begin errors++; $display("FAIL reset_taken got %0b exp 0", PredTakenF); end
        checks++; if (PredTargetF !== 32'h104) begin errors++; $display("FAIL reset_target got %h exp 00000104", PredTargetF); end
        checks++; if (MispredictE !== 1'b0) begin errors++; $display("FAIL reset_mispredict got %0b exp 0", MispredictE); end
        for (int i = 0; i < 64; i++) begin
            PCF = 32'h1000 + i * 4;
            exp_t = 32'h1004 + i * 4;
            #1;
            checks++; if (PredTakenF !== 1'b0 || PredTargetF !== exp_t) begin
                errors++; $display("FAIL reset_miss_%0d got %0b/%h exp 0/%h", i, PredTakenF, PredTargetF, exp_t);
            end
        end
        PCF = 32'hFFFF_FFFC; #1;
        checks++; if (PredTargetF !== 32'h0) begin errors++; $display("FAIL pc_wrap got %h exp 00000000", PredTargetF); end
    endtask

    task automatic test_btype_taken();
        step();
        PCF = 32'h100;
        drive_update(2'b11, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104); #4;
        checks++; if (MispredictE !== 1'b1) begin errors++; $display("FAIL bt_mispredict got %0b exp 1", MispredictE); end
        checks++; if (PredTargetF !== 32'h104) begin errors++; $display("FAIL bt_pre_target got %h exp 00000104", PredTargetF); end
        step(); idle_inputs(); #4;
        checks++; if (PredTakenF !== 1'b1 || PredTargetF !== 32'h80) begin
            errors++; $display("FAIL bt_alloc got %0b/%h exp 1/00000080", PredTakenF, PredTargetF);
        end
    endtask

    task automatic test_stall();
        PCF = 32'h100;
        drive_update(2'b11, 32'h100, 1'b1, 32'h90, 1'b1, 32'h80); StallE = 1'b1; #4;
        checks++; if (MispredictE !== 1'b1) begin errors++; $display("FAIL stall_mispredict got %0b exp 1", MispredictE); end
        step(); idle_inputs(); #4;
        checks++; if (PredTakenF !== 1'b1 || PredTargetF !== 32'h80) begin
            errors++; $display("FAIL stall_no_update got %0b/%h exp 1/00000080", PredTakenF, PredTargetF);
        end
        PCF = 32'h104;
        drive_update(2'b11, 32'h104, 1'b0, 32'h0, 1'b0, 32'h108); #4;
        checks++; if (MispredictE !== 1'b0) begin errors++; $display("FAIL nt_miss_mispredict got %0b exp 0", MispredictE); end
        step(); idle_inputs(); #4;
        checks++; if (PredTakenF !== 1'b0 || PredTargetF !== 32'h108) begin
            errors++; $display("FAIL nt_miss_no_alloc got %0b/%h exp 0/00000108", PredTakenF, PredTargetF);
        end
    endtask

    task automatic test_saturation();
        PCF = 32'h100;
        drive_update(2'b11, 32'h100, 1'b0, 32'h0, 1'b1, 32'h80); #4;
        checks++; if (MispredictE !== 1'b1) begin errors++; $display("FAIL nt1_mispredict got %0b exp 1", MispredictE); end
        step(); idle_inputs(); #4;
        checks++; if (PredTakenF !== 1'b0 || PredTargetF !== 32'h80) begin
            errors++; $display("FAIL nt1_wnt got %0b/%h exp 0/00000080", PredTakenF, PredTargetF);
        end
        drive_update(2'b11, 32'h100, 1'b0, 32'h0, 1'b0, 32'h80); #4;
        checks++; if (MispredictE !== 1'b0) begin errors++; $display("FAIL nt2_mispredict got %0b exp 0", MispredictE); end
        step();
        drive_update(2'b11, 32'h100, 1'b0, 32'h0, 1'b0, 32'h80);
        step(); idle_inputs(); #4;
        checks++; if (PredTakenF !== 1'b0) begin errors++; $display("FAIL nt3_snt got %0b exp 0", PredTakenF); end
        drive_update(2'b11, 32'h100, 1'b1, 32'h80, 1'b0, 32'h80);
        step(); idle_inputs(); #4;
        checks++; if (PredTakenF !== 1'b0) begin errors++; $display("FAIL sat_low got %0b exp 0", PredTakenF); end
        drive_update(2'b11, 32'h100, 1'b1, 32'h80, 1'b0, 32'h80);
        step(); idle_inputs(); #4;
        checks++; if (PredTakenF !== 1'b1) begin errors++; $display("FAIL t_to_wt got %0b exp 1", PredTakenF); end
    endtask

    task automatic test_back_to_back();
        PCF = 32'h100;
        drive_update(2'b11, 32'h100, 1'b1, 32'hC0, 1'b1, 32'h80); #4;
        checks++; if (PredTargetF !== 32'h80) begin errors++; $display("FAIL rdw_old got %h exp 00000080", PredTargetF); end
        checks++; if (MispredictE !== 1'b1) begin errors++; $display("FAIL rdw_mispredict got %0b exp 1", MispredictE); end
        step(); idle_inputs(); #4;
        checks++; if (PredTakenF !== 1'b1 || PredTargetF !== 32'hC0) begin
            errors++; $display("FAIL rdw_new got %0b/%h exp 1/000000c0", PredTakenF, PredTargetF);
        end
    endtask

    task automatic test_jump();
        PCF = 32'h200;
        drive_update(2'b01, 32'h200, 1'b1, 32'h400, 1'b1, 32'h3FC); #4;
        checks++; if (MispredictE !== 1'b1) begin errors++; $display("FAIL jmp_mispredict got %0b exp 1", MispredictE); end
        step(); idle_inputs(); #4;
        checks++; if (PredTakenF !== 1'b1 || PredTargetF !== 32'h400) begin
            errors++; $display("FAIL jmp_alloc got %0b/%h exp 1/00000400", PredTakenF, PredTargetF);
        end
        PCF = 32'h100; #1;
        checks++; if (PredTakenF !== 1'b0 || PredTargetF !== 32'h104) begin
            errors++; $display("FAIL evicted got %0b/%h exp 0/00000104", PredTakenF, PredTargetF);
        end
        PCF = 32'h200;
        drive_update(2'b11, 32'h200, 1'b0, 32'h0, 1'b1, 32'h400);
        step(); idle_inputs(); #4;
        checks++; if (PredTakenF !== 1'b1) begin errors++; $display("FAIL jmp_st got %0b exp 1", PredTakenF); end
        drive_update(2'b10, 32'h300, 1'b1, 32'h500, 1'b0, 32'h304); #4;
        checks++; if (MispredictE !== 1'b0) begin errors++; $display("FAIL reserved_mispredict got %0b exp 0", MispredictE); end
        step(); idle_inputs(); #4;
        checks++; if (PredTakenF !== 1'b1 || PredTargetF !== 32'h400) begin
            errors++; $display("FAIL reserved_no_update got %0b/%h exp 1/00000400", PredTakenF, PredTargetF);
        end
    endtask

    task automatic test_reset_with_update();
        reset = 1'b1;
        drive_update(2'b01, 32'h104, 1'b1, 32'h700, 1'b0, 32'h108);
        step(); reset = 1'b0; idle_inputs();
        PCF = 32'h104; #4;
        checks++; if (PredTakenF !== 1'b0 || PredTargetF !== 32'h108) begin
            errors++; $display("FAIL rst_drop got %0b/%h exp 0/00000108", PredTakenF, PredTargetF);
        end
        PCF = 32'h200; #1;
        checks++; if (PredTakenF !== 1'b0 || PredTargetF !== 32'h204) begin
            errors++; $display("FAIL rst_clear got %0b/%h exp 0/00000204", PredTakenF, PredTargetF);
        end
    endtask

    initial begin
        test_reset();
        test_btype_taken();
        test_stall();
        test_saturation();
        test_back_to_back();
        test_jump();
        test_reset_with_update();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-stage dynamic branch predictor that sits directly upstream of branch resolution.
- Predicts taken/not-taken and the target for the PC being fetched, using a direct-mapped BTB and a table of 2-bit saturating counters.
- Trains on resolved outcomes (PCSrcResE, BranchOpE) from execute.
- Flags mispredictions so hazard control can flush and redirect.

Parameters:
- IDX_BITS, 6, log2 of table entries (64 BTB entries, 64 counters).
- XLEN, 32, PC and target width.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- PCF  input  XLEN  fetch-stage PC to look up
- PredTakenF  output  1  prediction for PCF: taken
- PredTargetF  output  XLEN  predicted target for PCF
- PCE  input  XLEN  PC of the instruction in execute
- BranchOpE  input  2  00 non-branch, 01 jump, 11 B-type, 10 reserved
- PCSrcResE  input  1  resolved outcome from branch resolution
- PCTargetE  input  XLEN  resolved target in execute
- PredTakenE  input  1  PredTakenF of the execute instruction, pipelined down
- PredTargetE  input  XLEN  PredTargetF of the execute instruction, pipelined down
- StallE  input  1  execute stalled; suppresses training
- MispredictE  output  1  prediction wrong; flush and redirect to correct PC

Behaviour:
- Clocking: single clock domain. Reset is synchronous and active-high, sampled on posedge clk.
- Reset action: clear every BTB valid bit and set every counter to WNT (01).
  - Reset has priority over a same-cycle update.
  - Reset mid-stream discards all training.
- Indexing:
  - idx = PC[IDX_BITS+1:2].
  - tag = PC[XLEN-1:IDX_BITS+2].
  - Entry fields: valid, tag, target, cnt[1:0].
- Lookup (combinational, zero-cycle latency from PCF):
  - hit = valid[idx] && tag match.
  - PredTakenF = hit && cnt[idx][1].
  - PredTargetF = target[idx] when hit, otherwise PCF+4.
- Counter states: SNT 00, WNT 01, WT 10, ST 11. Saturating: SNT does not go below 00; ST does not go above 11.
- Training occurs on posedge when UpdateE = !StallE && BranchOpE[0]. Applies to PCE's entry:
  - B-type (11), taken:
    - if hit: cnt+1 and target <= PCTargetE;
    - if miss: allocate (valid=1, tag, target=PCTargetE, cnt=WT).
  - B-type (11), not taken:
    - if hit: cnt-1;
    - if miss: no allocation, no state change.
  - Jump (01): allocate or overwrite (valid=1, tag, target=PCTargetE, cnt=ST).
  - Allocation on a conflicting tag evicts the old entry unconditionally.
- BranchOpE 00 or 10: no update. MispredictE = 0.
- MispredictE (combinational) = BranchOpE[0] && ((PCSrcResE != PredTakenE) || (PCSrcResE && PredTargetE != PCTargetE)).
  - Asserts regardless of StallE.
  - Consumer samples it only when not stalled.
- Read-during-write: if lookup idx equals update idx in the same cycle, lookup returns the pre-update contents. The new value is visible the following cycle.
- Arithmetic: no width growth.
  - PCF+4 wraps modulo 2^XLEN.
  - Counter arithmetic is 2-bit saturating.

Optional Feature:
- Macro: BP_GSHARE_EN
- Defined:
  - Adds an IDX_BITS-wide global history register (GHR), reset to 0.
  - Counter index = idx XOR GHR for both lookup and update. The update uses the GHR value before this cycle's shift.
  - On every B-type UpdateE: GHR <= {GHR[IDX_BITS-2:0], PCSrcResE}.
  - Jumps do not shift the GHR.
  - BTB tag, target and valid stay PC-indexed.
  - Entry allocation writes the counter at the XORed index.
- Undefined: no GHR; counters are PC-indexed as above. Port list is identical in both builds.

Test Plan:
- Reset, then PCF=0x100 -> PredTakenF=0, PredTargetF=0x104. All 64 entries report miss.
- B-type at PCE=0x100, taken, PCTargetE=0x80, PredTakenE=0 -> MispredictE=1.
  - Next cycle, PCF=0x100 gives PredTakenF=1 and PredTargetF=0x80 (cnt=WT).
- Same branch resolved not-taken twice -> cnt 10→01→00, PredTakenF=0. A third not-taken keeps cnt=00 (saturation).
- Jump at PCE=0x200, PCTargetE=0x400, PredTakenE=1, PredTargetE=0x3FC -> MispredictE=1 (target mismatch). Entry is set to ST with target 0x400.
- Same-cycle case: PCF=PCE=0x100 while an update is in flight -> the lookup shows the old value; the new value appears one cycle later.
- Other cases:
  - StallE=1 during a taken B-type -> no table change.
  - reset asserted with UpdateE -> table cleared; the update is dropped.
  - With BP_GSHARE_EN: GHR after taken, not-taken, taken = 0b000101.
